// File: rtl/fx_arb.sv
`default_nettype none
// ============================================================================
// Module   : fx_arb
// Purpose  : Two-master round-robin arbiter for the fx register bus. It shares
//            one fx slave bus between m0 (UART) and m1 (on-chip master),
//            issues one-cycle fx_wr / fx_rd strobes, and returns read data
//            RD_LAT cycles after the read strobe.
// Ports    : clk_sys, rst_n (async, active low)
//            m0_*/m1_*  : req/we/addr/data/lock in, ack/q out
//            fx_wr, fx_data, fx_waddr : write strobe and payload
//            fx_rd, fx_raddr          : read strobe and address
//            fx_q       : OR-combined slave read data
//            busy       : high whenever the FSM is not in IDLE
// Options  : FX_ARB_LOCK_EN - honour m0_lock / m1_lock grant locking.
//            Without it the lock ports are ignored (pure round-robin).
// Revision : 1.0 - initial release
// ============================================================================
module fx_arb #(
    parameter int RD_LAT = 1
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic        m0_we,
    input  logic        m1_we,
    input  logic [21:0] m0_addr,
    input  logic [21:0] m1_addr,
    input  logic [7:0]  m0_data,
    input  logic [7:0]  m1_data,
    input  logic        m0_lock,
    input  logic        m1_lock,
    output logic        m0_ack,
    output logic        m1_ack,
    output logic [7:0]  m0_q,
    output logic [7:0]  m1_q,
    output logic        fx_wr,
    output logic [7:0]  fx_data,
    output logic [21:0] fx_waddr,
    output logic        fx_rd,
    output logic [21:0] fx_raddr,
    input  logic [7:0]  fx_q,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR    = 3'd1,
        S_RD    = 3'd2,
        S_RWAIT = 3'd3,
        S_RACK  = 3'd4
    } state_t;

    // Counter load so that fx_q is sampled exactly RD_LAT edges after fx_rd.
    localparam logic [3:0] LAT_LOAD = 4'(RD_LAT - 1);

    state_t      state_q;
    logic        gnt_q;        // 0 = m0, 1 = m1
    logic        last_gnt_q;
    logic [3:0]  cnt_q;
    logic        fx_wr_q;
    logic        fx_rd_q;
    logic [7:0]  fx_data_q;
    logic [21:0] fx_waddr_q;
    logic [21:0] fx_raddr_q;
    logic        m0_ack_q;
    logic        m1_ack_q;
    logic [7:0]  m0_rdata_q;
    logic [7:0]  m1_rdata_q;
    logic        busy_q;

    logic        req0_d;
    logic        req1_d;
    logic        gnt_valid_d;
    logic        gnt_d;
    logic        sel_we_d;
    logic [21:0] sel_addr_d;
    logic [7:0]  sel_data_d;

`ifdef FX_ARB_LOCK_EN
    logic lock_q;
    logic lock_owner_q;
    logic owner_lock_d;

    assign owner_lock_d = lock_owner_q ? m1_lock : m0_lock;
`else
    logic unused_lock;

    assign unused_lock = m0_lock ^ m1_lock;
`endif

    // Arbitration: a held lock masks the other master; otherwise a tie goes
    // to the master that was not served last.
    always_comb begin
        req0_d = m0_req;
        req1_d = m1_req;
`ifdef FX_ARB_LOCK_EN
        if (lock_q && owner_lock_d) begin
            req0_d = m0_req & ~lock_owner_q;
            req1_d = m1_req &  lock_owner_q;
        end
`endif
        gnt_valid_d = req0_d | req1_d;
        gnt_d       = (req0_d && req1_d) ? ~last_gnt_q : req1_d;
        sel_we_d    = gnt_d ? m1_we   : m0_we;
        sel_addr_d  = gnt_d ? m1_addr : m0_addr;
        sel_data_d  = gnt_d ? m1_data : m0_data;
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            gnt_q        <= 1'b0;
            last_gnt_q   <= 1'b1;
            cnt_q        <= 4'd0;
            fx_wr_q      <= 1'b0;
            fx_rd_q      <= 1'b0;
            fx_data_q    <= 8'd0;
            fx_waddr_q   <= 22'd0;
            fx_raddr_q   <= 22'd0;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
            m0_rdata_q   <= 8'd0;
            m1_rdata_q   <= 8'd0;
            busy_q       <= 1'b0;
`ifdef FX_ARB_LOCK_EN
            lock_q       <= 1'b0;
            lock_owner_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
`ifdef FX_ARB_LOCK_EN
                    // Lock is released for good once the owner drops it in IDLE.
                    if (lock_q && !owner_lock_d) begin
                        lock_q <= 1'b0;
                    end
`endif
                    if (gnt_valid_d) begin
                        gnt_q  <= gnt_d;
                        busy_q <= 1'b1;
                        if (sel_we_d) begin
                            // Strobe and ack are registered so they appear in
                            // the WR cycle itself.
                            fx_wr_q    <= 1'b1;
                            fx_waddr_q <= sel_addr_d;
                            fx_data_q  <= sel_data_d;
                            m0_ack_q   <= ~gnt_d;
                            m1_ack_q   <= gnt_d;
                            state_q    <= S_WR;
                        end else begin
                            fx_rd_q    <= 1'b1;
                            fx_raddr_q <= sel_addr_d;
                            state_q    <= S_RD;
                        end
                    end
                end
                S_WR: begin
                    fx_wr_q    <= 1'b0;
                    m0_ack_q   <= 1'b0;
                    m1_ack_q   <= 1'b0;
                    busy_q     <= 1'b0;
                    last_gnt_q <= gnt_q;
`ifdef FX_ARB_LOCK_EN
                    lock_q       <= gnt_q ? m1_lock : m0_lock;
                    lock_owner_q <= gnt_q;
`endif
                    state_q    <= S_IDLE;
                end
                S_RD: begin
                    fx_rd_q <= 1'b0;
                    cnt_q   <= LAT_LOAD;
                    state_q <= S_RWAIT;
                end
                S_RWAIT: begin
                    if (cnt_q == 4'd0) begin
                        if (gnt_q) begin
                            m1_rdata_q <= fx_q;
                            m1_ack_q   <= 1'b1;
                        end else begin
                            m0_rdata_q <= fx_q;
                            m0_ack_q   <= 1'b1;
                        end
                        state_q <= S_RACK;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RACK: begin
                    m0_ack_q   <= 1'b0;
                    m1_ack_q   <= 1'b0;
                    busy_q     <= 1'b0;
                    last_gnt_q <= gnt_q;
`ifdef FX_ARB_LOCK_EN
                    lock_q       <= gnt_q ? m1_lock : m0_lock;
                    lock_owner_q <= gnt_q;
`endif
                    state_q    <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign m0_ack   = m0_ack_q;
    assign m1_ack   = m1_ack_q;
    assign m0_q     = m0_rdata_q;
    assign m1_q     = m1_rdata_q;
    assign fx_wr    = fx_wr_q;
    assign fx_data  = fx_data_q;
    assign fx_waddr = fx_waddr_q;
    assign fx_rd    = fx_rd_q;
    assign fx_raddr = fx_raddr_q;
    assign busy     = busy_q;

endmodule
`default_nettype wire
